fifo_rr_dispatcher: RTL and testbench

Round-robin dispatch stage that sits directly downstream of a bank of four 6-bit FIFOs and feeds a second bank of four FIFOs. It pops one word at a time from a non-empty input FIFO. It then pushes that word into the output FIFO named by the word's destination field. While that output FIFO has `Pausa` asserted, the word is held rather than dropped.

---
 rtl/dispatch_pkg.sv | 21 ++
 rtl/rr_select.sv | 28 ++
 rtl/fifo_rr_dispatcher.sv | 115 +++++++++++
 tb/tb_fifo_rr_dispatcher.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared definitions for the round-robin FIFO dispatcher: FSM encoding,
// default widths and the destination-field extractor.
package dispatch_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 6;
    localparam int unsigned DEF_DEST_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Destination lives in the top dest_w bits of a data_w-bit word.
    function automatic logic [31:0] dest_of(input logic [31:0] word,
                                            input int unsigned data_w,
                                            input int unsigned dest_w);
        return (word >> (data_w - dest_w)) & ((32'd1 << dest_w) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N_IN.
module rr_select #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_IN-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] gnt
);

    int unsigned idx;

    always_comb begin
        any = 1'b0;
        gnt = '0;
        idx = 0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            idx = (32'(ptr) + i) % N_IN;
            if (!any && req[PTR_W'(idx)]) begin
                any = 1'b1;
                gnt = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_dispatcher.sv
// Pops one word at a time from a bank of input FIFOs in round-robin order and
// pushes it to the output FIFO selected by its destination field.
module fifo_rr_dispatcher
    import dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEST_WIDTH = DEF_DEST_WIDTH,
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 4,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_IN-1:0]            fifo_empty,
    input  logic [N_IN*DATA_WIDTH-1:0] fifo_data_in,
    input  logic [N_OUT-1:0]           pause_in,
    output logic [N_IN-1:0]            pop,
    output logic [N_OUT-1:0]           push,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       busy
);

    localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        gnt;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   hold;

    logic                    sel_any;
    logic [PTR_W-1:0]        sel_gnt;
    logic [DATA_WIDTH-1:0]   in_words [N_IN];
    logic [DATA_WIDTH-1:0]   cap_word;
    logic [DEST_WIDTH-1:0]   cap_dest;
    logic [DEST_WIDTH-1:0]   hold_dest;

    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign in_words[i] = fifo_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign cap_word  = in_words[gnt];
    assign cap_dest  = DEST_WIDTH'(dest_of(32'(cap_word), DATA_WIDTH, DEST_WIDTH));
    assign hold_dest = DEST_WIDTH'(dest_of(32'(hold), DATA_WIDTH, DEST_WIDTH));

    rr_select #(
        .N_IN  (N_IN),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req (~fifo_empty),
        .ptr (rr_ptr),
        .any (sel_any),
        .gnt (sel_gnt)
    );

    // Only one word is ever in flight, so the input FIFOs' lagging empty
    // flags are never consulted for a FIFO that was just popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt      <= '0;
            cnt      <= '0;
            hold     <= '0;
            pop      <= '0;
            push     <= '0;
            data_out <= '0;
            busy     <= 1'b0;
        end else begin
            pop  <= '0;
            push <= '0;
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        pop    <= N_IN'(1) << sel_gnt;
                        gnt    <= sel_gnt;
                        cnt    <= CNT_W'(RD_LAT);
                        rr_ptr <= (sel_gnt == PTR_W'(N_IN - 1)) ? '0 : sel_gnt + PTR_W'(1);
                        state  <= WAIT;
                        busy   <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (pause_in[cap_dest]) begin
                            hold  <= cap_word;
                            state <= HOLD;
                        end else begin
                            data_out <= cap_word;
                            push     <= N_OUT'(1) << cap_dest;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // Head-of-line blocking: only the held word's own pause matters.
                    if (!pause_in[hold_dest]) begin
                        data_out <= hold;
                        push     <= N_OUT'(1) << hold_dest;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_dispatcher.sv
// Directed bench for fifo_rr_dispatcher with hand-computed expectations.
module tb_fifo_rr_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [23:0] fifo_data_in;
    logic [3:0]  pause_in;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [5:0]  data_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Word held at the head of each input FIFO and the push strobe it maps to.
    logic [5:0] word     [4] = '{6'b10_0101, 6'b01_1010, 6'b00_0011, 6'b11_0001};
    logic [3:0] push_of  [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};

    fifo_rr_dispatcher dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data_in (fifo_data_in),
        .pause_in     (pause_in),
        .pop          (pop),
        .push         (push),
        .data_out     (data_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_io(input string tag, input logic [3:0] pop_e,
                            input logic [3:0] push_e, input logic busy_e);
        check({tag, "/pop"},  32'(pop),  32'(pop_e));
        check({tag, "/push"}, 32'(push), 32'(push_e));
        check({tag, "/busy"}, 32'(busy), 32'(busy_e));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic rr_seq(input string tag, input logic [3:0] empt,
                          input int o0, input int o1, input int o2, input int o3, input int o4);
        int ord [5];
        ord = '{o0, o1, o2, o3, o4};
        fifo_empty = 4'b1111;
        pause_in   = 4'b0000;
        do_reset();
        fifo_empty = empt;
        for (int n = 0; n < 5; n++) begin
            logic [3:0] oh;
            oh = 4'b0001 << ord[n];
            tick();
            check_io({tag, "/pop_cyc"}, oh, 4'b0000, 1'b1);
            tick();
            check_io({tag, "/wait_cyc"}, 4'b0000, 4'b0000, 1'b1);
            tick();
            check_io({tag, "/push_cyc"}, 4'b0000, push_of[ord[n]], 1'b0);
            check({tag, "/data"}, 32'(data_out), 32'(word[ord[n]]));
        end
    endtask

    initial begin
        reset        = 1'b1;
        fifo_empty   = 4'b0000;
        pause_in     = 4'b0000;
        fifo_data_in = {word[3], word[2], word[1], word[0]};

        // Reset with every input non-empty: nothing moves.
        tick();
        check_io("reset_c1", 4'b0000, 4'b0000, 1'b0);
        check("reset_c1/data", 32'(data_out), 32'd0);
        tick();
        check_io("reset_c2", 4'b0000, 4'b0000, 1'b0);
        check("reset_c2/data", 32'(data_out), 32'd0);
        reset = 1'b0;
        tick();
        check_io("reset_first_pop", 4'b0001, 4'b0000, 1'b1);

        // Single word from input 0 to destination 2.
        fifo_empty = 4'b1111;
        do_reset();
        fifo_empty = 4'b1110;
        tick();
        check_io("single_pop", 4'b0001, 4'b0000, 1'b1);
        fifo_empty = 4'b1111;
        tick();
        check_io("single_wait", 4'b0000, 4'b0000, 1'b1);
        tick();
        check_io("single_push", 4'b0000, 4'b0100, 1'b0);
        check("single_data", 32'(data_out), 32'h25);
        tick();
        check_io("single_idle", 4'b0000, 4'b0000, 1'b0);
        check("single_data_kept", 32'(data_out), 32'h25);

        // Round robin, all inputs ready, then with input 1 empty.
        rr_seq("rr_all", 4'b0000, 0, 1, 2, 3, 0);
        rr_seq("rr_skip1", 4'b0010, 0, 2, 3, 0, 2);

        // Backpressure on destination 3; other inputs become ready meanwhile.
        fifo_empty = 4'b1111;
        pause_in   = 4'b1000;
        do_reset();
        fifo_empty = 4'b0111;
        tick();
        check_io("bp_pop", 4'b1000, 4'b0000, 1'b1);
        fifo_empty = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_io("bp_hold", 4'b0000, 4'b0000, 1'b1);
        end
        pause_in = 4'b0111;
        tick();
        check_io("bp_release", 4'b0000, 4'b1000, 1'b0);
        check("bp_data", 32'(data_out), 32'h31);
        pause_in = 4'b0000;
        tick();
        check_io("bp_next_pop", 4'b0001, 4'b0000, 1'b1);

        // Pause on other destinations does not stall a destination-2 word.
        fifo_empty = 4'b1111;
        do_reset();
        pause_in   = 4'b1011;
        fifo_empty = 4'b1110;
        tick();
        check_io("other_pause_pop", 4'b0001, 4'b0000, 1'b1);
        fifo_empty = 4'b1111;
        tick();
        tick();
        check_io("other_pause_push", 4'b0000, 4'b0100, 1'b0);
        check("other_pause_data", 32'(data_out), 32'h25);

        // Reset one cycle after a pop: word dropped, pointer back to 0.
        pause_in   = 4'b0000;
        fifo_empty = 4'b1111;
        do_reset();
        fifo_empty = 4'b1101;
        tick();
        check_io("midwait_pop", 4'b0010, 4'b0000, 1'b1);
        reset = 1'b1;
        tick();
        check_io("midwait_rst", 4'b0000, 4'b0000, 1'b0);
        reset      = 1'b0;
        fifo_empty = 4'b0000;
        tick();
        check_io("midwait_ptr0", 4'b0001, 4'b0000, 1'b1);
        tick();
        check_io("midwait_nopush", 4'b0000, 4'b0000, 1'b1);
        tick();
        check_io("midwait_push_in0", 4'b0000, 4'b0100, 1'b0);
        check("midwait_data", 32'(data_out), 32'h25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
